// File: rtl/iram_pkg.sv
// iram_pkg: shared state codes, NOP word and default parameters for the program RAM.
package iram_pkg;
  localparam logic [1:0] CLEAR = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] LOAD = 2'd2;
  localparam logic [15:0] NOP = 16'h0000;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF = 128;
  localparam int REG_OUT_DEF = 0;
endpackage

// File: rtl/iram_word_asm.sv
// iram_word_asm: pairs load bytes into little-endian words, padding a lone low byte on done.
module iram_word_asm
  import iram_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        restart_i,
  input  logic        xfer_i,
  input  logic        done_i,
  input  logic [7:0]  byte_i,
  output logic        wr_o,
  output logic [15:0] wdata_o
);
  logic half_q, half_d, pair, pend;
  logic [7:0] low_q, low_d;
  always_comb begin
    pair = xfer_i && half_q;
    pend = xfer_i ? !half_q : half_q;
    low_d = (xfer_i && !half_q) ? byte_i : low_q;
    wr_o = pair || (done_i && pend);
    wdata_o = pair ? {byte_i, low_q} : {8'h00, low_d};
    half_d = (restart_i || done_i) ? 1'b0 : pend;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      half_q <= 1'b0;
      low_q <= 8'h00;
    end else begin
      half_q <= half_d;
      low_q <= low_d;
    end
  end
endmodule

// File: rtl/iram_prog.sv
// iram_prog: instruction RAM cleared after reset, fetchable in RUN, loadable from a byte stream.
module iram_prog
  import iram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int REG_OUT = REG_OUT_DEF
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] Q,
  output logic              MISALIGN,
  output logic              BUSY,
  input  logic              LD_START,
  input  logic              LD_VALID,
  input  logic [7:0]        LD_BYTE,
  output logic              LD_READY,
  input  logic              LD_DONE,
  output logic [ADDR_W-1:0] LD_COUNT
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  logic [1:0] state_q, state_d;
  logic [ADDR_W-2:0] clr_q, clr_d, waddr, idx;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_q, wd;
  logic [15:0] asm_data;
  logic clr, run, ld, xfer, done, wr, we;
  iram_word_asm u_asm (
    .clk(CLK), .rst(RESET), .restart_i(LD_START), .xfer_i(xfer), .done_i(done),
    .byte_i(LD_BYTE), .wr_o(wr), .wdata_o(asm_data)
  );
  // LD_START wins over a same-cycle byte or done: the restart discards them
  always_comb begin
    clr = state_q == CLEAR;
    run = state_q == RUN;
    ld = !clr && !run;
    xfer = ld && LD_VALID && !LD_START;
    done = ld && LD_DONE && !LD_START;
    idx = ADDR[ADDR_W-1:1];
    we = clr || wr;
    waddr = clr ? clr_q : cnt_q[ADDR_W-2:0];
    wd = clr ? DATA_W'(NOP) : DATA_W'(asm_data);
    clr_d = clr ? clr_q + (ADDR_W-1)'(1) : '0;
    cnt_d = (!clr && LD_START) ? '0 : wr ? cnt_q + ADDR_W'(1) : cnt_q;
    state_d = clr ? (clr_q == LAST[ADDR_W-2:0] ? RUN : CLEAR)
            : run ? (LD_START ? LOAD : RUN)
            : LD_START ? LOAD
            : ((wr && cnt_q == LAST) || done) ? RUN : LOAD;
    BUSY = !run;
    LD_READY = ld;
    MISALIGN = ADDR[0];
    LD_COUNT = cnt_q;
    Q = !run ? '0 : (REG_OUT != 0) ? rd_q : mem[idx];
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= CLEAR;
      clr_q <= '0;
      cnt_q <= '0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      cnt_q <= cnt_d;
      rd_q <= run ? mem[idx] : '0;
    end
  end
  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wd;
  end
endmodule

// File: tb/tb_iram_prog.sv
// tb_iram_prog: directed checks of clear, fetch and byte loading on combinational and registered variants.
module tb_iram_prog;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] addr = 8'h00;
  logic ld_start = 1'b0, ld_valid = 1'b0, ld_done = 1'b0;
  logic [7:0] ld_byte = 8'h00;
  logic [15:0] q0, q1;
  logic mis0, mis1, busy0, busy1, rdy0, rdy1;
  logic [7:0] cnt0, cnt1;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  iram_prog #(.REG_OUT(0)) dut0 (
    .CLK(clk), .RESET(rst), .ADDR(addr), .Q(q0), .MISALIGN(mis0), .BUSY(busy0),
    .LD_START(ld_start), .LD_VALID(ld_valid), .LD_BYTE(ld_byte), .LD_READY(rdy0),
    .LD_DONE(ld_done), .LD_COUNT(cnt0)
  );
  iram_prog #(.REG_OUT(1)) dut1 (
    .CLK(clk), .RESET(rst), .ADDR(addr), .Q(q1), .MISALIGN(mis1), .BUSY(busy1),
    .LD_START(ld_start), .LD_VALID(ld_valid), .LD_BYTE(ld_byte), .LD_READY(rdy1),
    .LD_DONE(ld_done), .LD_COUNT(cnt1)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic send(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_byte = b;
    step();
    ld_valid = 1'b0;
  endtask
  task automatic start();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
  endtask
  task automatic finish_load();
    ld_done = 1'b1;
    step();
    ld_done = 1'b0;
  endtask
  task automatic wait_clear(input string tag);
    int n = 0;
    while (busy0 && n < 300) begin
      step();
      ld_start = 1'b0;
      n++;
    end
    chk(tag, n, 128);
    chk({tag, "_r"}, {31'd0, busy1}, 0);
  endtask
  task automatic fetch(input string tag, input logic [7:0] a, input logic [15:0] exp);
    addr = a;
    #1;
    chk({tag, "_comb"}, q0, exp);
    step();
    chk({tag, "_reg"}, q1, exp);
  endtask
  initial begin
    step();
    step();
    chk("rst_busy", {busy0, busy1}, 2'b11);
    chk("rst_q", {q0, q1}, 0);
    chk("rst_ready", {rdy0, rdy1}, 0);
    chk("rst_count", cnt0, 0);
    rst = 1'b0;
    wait_clear("clear_len");
    fetch("run_nop", 8'h10, 16'h0000);
    chk("run_busy", busy0, 0);
    start();
    chk("load_ready", {rdy0, busy0, rdy1}, 3'b111);
    chk("load_q", q0, 0);
    chk("load_count0", cnt0, 0);
    send(8'h01); send(8'hF0); send(8'h7F); send(8'h51);
    finish_load();
    chk("l1_count", {cnt0, cnt1}, 16'h0202);
    chk("l1_run", {busy0, rdy0}, 0);
    fetch("l1_w0", 8'h00, 16'hF001);
    chk("l1_misalign0", mis0, 0);
    fetch("l1_w1", 8'h02, 16'h517F);
    start();
    send(8'hAA); send(8'hBB); send(8'hCC);
    finish_load();
    chk("pad_count", cnt0, 2);
    addr = 8'h03;
    #1;
    chk("pad_misalign", {mis0, mis1}, 2'b11);
    fetch("pad_w1", 8'h03, 16'h00CC);
    fetch("pad_w0", 8'h01, 16'hBBAA);
    start();
    send(8'h11);
    ld_done = 1'b1;
    send(8'h22);
    ld_done = 1'b0;
    chk("bd_pair_count", cnt0, 1);
    chk("bd_pair_run", busy0, 0);
    fetch("bd_pair_w0", 8'h00, 16'h2211);
    start();
    send(8'h11); send(8'h22);
    ld_done = 1'b1;
    send(8'h33);
    ld_done = 1'b0;
    chk("bd_pad_count", cnt0, 2);
    fetch("bd_pad_w1", 8'h02, 16'h0033);
    start();
    ld_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      ld_byte = 8'(i);
      step();
    end
    chk("full_ready", {rdy0, rdy1}, 0);
    chk("full_busy", busy0, 0);
    ld_valid = 1'b0;
    chk("full_count", cnt0, 8'h80);
    fetch("full_w127", 8'hFE, 16'hFFFE);
    fetch("full_w0", 8'h00, 16'h0100);
    finish_load();
    chk("done_in_run", {busy0, cnt0}, {1'b0, 8'h80});
    start();
    send(8'h10); send(8'h20); send(8'h30);
    start();
    chk("restart_count", cnt0, 0);
    chk("restart_ready", rdy0, 1);
    send(8'h40); send(8'h50);
    finish_load();
    chk("restart_count1", cnt0, 1);
    fetch("restart_w0", 8'h00, 16'h5040);
    fetch("restart_keep_w1", 8'h02, 16'h0302);
    start();
    for (int i = 0; i < 6; i++) send(8'hE0 + 8'(i));
    chk("mid_count", cnt0, 3);
    ld_valid = 1'b1;
    ld_byte = 8'h99;
    rst = 1'b1;
    step();
    rst = 1'b0;
    ld_valid = 1'b0;
    chk("mid_rst_count", cnt0, 0);
    ld_start = 1'b1;
    wait_clear("mid_clear_len");
    chk("mid_ignore_start", {busy0, rdy0}, 0);
    for (int a = 0; a < 128; a++) begin
      addr = 8'(a * 2);
      #1;
      chk("mid_zero", q0, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
